// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        is_byte;
    } stb_entry_t;

    localparam int STB_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/dmem_arbiter_stb_fifo.sv
// rtl/dmem_arbiter_stb_fifo.sv - in-order store buffer with word-address hazard compare
module stb_fifo
    import dmem_arbiter_pkg::*;
#(
    parameter  int DEPTH = STB_DEPTH_DEFAULT,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  stb_entry_t       push_entry,
    input  logic             pop,
    output stb_entry_t       head_entry,
    output logic [PW:0]      count,
    output logic             not_full,
    input  logic [29:0]      cmp_word,
    output logic [DEPTH-1:0] match
);

    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    stb_entry_t       mem [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [PW:0]      count_q;
    logic [PW:0]      count_nxt;
    logic             do_push;
    logic             do_pop;

    // A push into a full buffer is dropped; a pop of an empty buffer is a no-op.
    assign do_push   = push && (count_q != FULL_CNT);
    assign do_pop    = pop && (count_q != '0);
    assign count_nxt = count_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};

    // Pointer, occupancy and registered room flag; stReady tracks the count it will see next cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            not_full <= 1'b1;
        end else begin
            if (do_push) begin
                tail_q          <= tail_q + PW'(1);
                valid_q[tail_q] <= 1'b1;
            end
            if (do_pop) begin
                head_q          <= head_q + PW'(1);
                valid_q[head_q] <= 1'b0;
            end
            count_q  <= count_nxt;
            not_full <= (count_nxt != FULL_CNT);
        end
    end

    // Entry storage needs no reset: the valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail_q] <= push_entry;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        assign match[i] = valid_q[i] && (mem[i].addr[31:2] == cmp_word);
    end

    assign head_entry = mem[head_q];
    assign count      = count_q;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - load/store arbiter for the single data-memory port; DMEM_ARB_AGE_EN adds store aging
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int STB_DEPTH = STB_DEPTH_DEFAULT,
    parameter int AGE_MAX   = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ldValid,
    output logic        ldReady,
    input  logic [31:0] ldPc,
    input  logic [31:0] ldAddr,
    input  logic        ldByte,
    input  logic        stValid,
    output logic        stReady,
    input  logic [31:0] stAddr,
    input  logic [31:0] stData,
    input  logic        stByte,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    output logic        memByte,
    input  logic        memAck,
    input  logic [31:0] memRdata,
    output logic        ldRespValid,
    output logic [31:0] ldRespPc,
    output logic [31:0] ldRespData,
    output logic        stbEmpty
);

    localparam int          PW       = $clog2(STB_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(STB_DEPTH);

    if (STB_DEPTH < 2 || STB_DEPTH > 16 || (STB_DEPTH & (STB_DEPTH - 1)) != 0 ||
        AGE_MAX < 1 || AGE_MAX > 15) begin : g_param_check
        $error("dmem_arbiter: unsupported STB_DEPTH or AGE_MAX");
    end

    arb_state_t           state_q;
    arb_state_t           state_d;
    stb_entry_t           st_entry;
    stb_entry_t           stb_head;
    logic [PW:0]          stb_count;
    logic [STB_DEPTH-1:0] stb_match;
    logic                 stb_pop;
    logic                 stb_full;
    logic                 stb_nonempty;
    logic                 ld_ok;
    logic                 aged;
    logic                 grant_ld;
    logic                 grant_st;
    logic [31:0]          ld_pc_q;

    assign st_entry     = '{addr: stAddr, data: stData, is_byte: stByte};
    assign stb_full     = (stb_count == FULL_CNT);
    assign stb_nonempty = (stb_count != '0);
    assign ld_ok        = ldValid && !(|stb_match);

    stb_fifo #(.DEPTH(STB_DEPTH)) u_stb (
        .clk        (clk),
        .rstn       (rstn),
        .push       (stValid),
        .push_entry (st_entry),
        .pop        (stb_pop),
        .head_entry (stb_head),
        .count      (stb_count),
        .not_full   (stReady),
        .cmp_word   (ldAddr[31:2]),
        .match      (stb_match)
    );

`ifdef DMEM_ARB_AGE_EN
    localparam logic [3:0] AGE_LIM = 4'(AGE_MAX);
    logic [3:0] age_q;

    assign aged = stb_nonempty && (age_q >= AGE_LIM);

    // Count loads that overtook a waiting store; any store grant restarts the count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            age_q <= 4'd0;
        end else if (grant_st) begin
            age_q <= 4'd0;
        end else if (grant_ld && stb_nonempty) begin
            age_q <= age_q + 4'd1;
        end
    end
`else
    assign aged = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant selection in IDLE and completion handling in LOAD/STORE.
    always_comb begin
        state_d  = state_q;
        grant_ld = 1'b0;
        grant_st = 1'b0;
        stb_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                if (stb_full || aged) begin
                    grant_st = 1'b1;
                end else if (ld_ok) begin
                    grant_ld = 1'b1;
                end else if (stb_nonempty) begin
                    grant_st = 1'b1;
                end
                if (grant_ld) begin
                    state_d = LOAD;
                end else if (grant_st) begin
                    state_d = STORE;
                end
            end
            LOAD: begin
                if (memAck) begin
                    state_d = IDLE;
                end
            end
            STORE: begin
                if (memAck) begin
                    state_d = IDLE;
                    stb_pop = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ldReady  = grant_ld;
    assign memReq   = (state_q != IDLE);
    assign stbEmpty = !stb_nonempty && (state_q != STORE);

    // Memory-port and response registers; the port is only loaded on a grant, so it holds while memReq is high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            memWe       <= 1'b0;
            memAddr     <= '0;
            memWdata    <= '0;
            memByte     <= 1'b0;
            ld_pc_q     <= '0;
            ldRespValid <= 1'b0;
            ldRespPc    <= '0;
            ldRespData  <= '0;
        end else begin
            if (grant_ld) begin
                memWe   <= 1'b0;
                memAddr <= ldAddr;
                memByte <= ldByte;
                ld_pc_q <= ldPc;
            end else if (grant_st) begin
                memWe    <= 1'b1;
                memAddr  <= stb_head.addr;
                memWdata <= stb_head.data;
                memByte  <= stb_head.is_byte;
            end
            ldRespValid <= (state_q == LOAD) && memAck;
            if ((state_q == LOAD) && memAck) begin
                ldRespPc   <= ld_pc_q;
                ldRespData <= memByte ? {24'h0, memRdata[7:0]} : memRdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard testbench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ldValid, ldReady, ldByte;
    logic [31:0] ldPc, ldAddr;
    logic        stValid, stReady, stByte;
    logic [31:0] stAddr, stData;
    logic        memReq, memWe, memByte, memAck;
    logic [31:0] memAddr, memWdata, memRdata;
    logic        ldRespValid, stbEmpty;
    logic [31:0] ldRespPc, ldRespData;

    always #5 clk = ~clk;

    dmem_arbiter #(.STB_DEPTH(4), .AGE_MAX(8)) dut (
        .clk(clk), .rstn(rstn),
        .ldValid(ldValid), .ldReady(ldReady), .ldPc(ldPc), .ldAddr(ldAddr), .ldByte(ldByte),
        .stValid(stValid), .stReady(stReady), .stAddr(stAddr), .stData(stData), .stByte(stByte),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata), .memByte(memByte),
        .memAck(memAck), .memRdata(memRdata),
        .ldRespValid(ldRespValid), .ldRespPc(ldRespPc), .ldRespData(ldRespData),
        .stbEmpty(stbEmpty)
    );

    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; logic is_byte; } mem_exp_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } resp_exp_t;

    mem_exp_t  exp_mem[$];
    resp_exp_t exp_resp[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic        ack_en;
    int          ack_delay;
    int          wait_cnt;
    logic        rd_fixed_en;
    logic [31:0] rd_fixed;

    logic        seen_ld_ready;
    int          last_grant_cyc, last_resp_cyc, last_st_ack_cyc, req_high_cyc, resp_count;
    logic        prev_req;
    logic [65:0] held_port;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] a, input logic b);
        logic [31:0] w;
        w = rd_fixed_en ? rd_fixed : mem_model(a);
        return b ? {24'h0, w[7:0]} : w;
    endfunction

    task automatic tick();
        mem_exp_t  e;
        resp_exp_t r;
        @(negedge clk);
        cyc++;
        seen_ld_ready = ldReady;
        if (ldReady) last_grant_cyc = cyc;
        if (rstn && memReq) begin
            req_high_cyc++;
            if (prev_req) begin
                vectors++;
                if ({memWe, memByte, memAddr, memWdata} !== held_port) begin
                    miscompares++;
                    $display("FAIL port_stable cyc=%0d got=%h required=%h", cyc,
                             {memWe, memByte, memAddr, memWdata}, held_port);
                end
            end
            held_port = {memWe, memByte, memAddr, memWdata};
        end
        prev_req = rstn && memReq;
        if (rstn && memReq && memAck) begin
            if (memWe) last_st_ack_cyc = cyc;
            vectors++;
            if (exp_mem.size() == 0) begin
                miscompares++;
                $display("FAIL mem_unexpected cyc=%0d got we=%b addr=%h required none", cyc, memWe, memAddr);
            end else begin
                e = exp_mem.pop_front();
                if (memWe !== e.we || memAddr !== e.addr || memByte !== e.is_byte ||
                    (e.we && memWdata !== e.data)) begin
                    miscompares++;
                    $display("FAIL mem_access cyc=%0d got we=%b addr=%h wd=%h byte=%b required we=%b addr=%h wd=%h byte=%b",
                             cyc, memWe, memAddr, memWdata, memByte, e.we, e.addr, e.data, e.is_byte);
                end
            end
        end
        if (ldRespValid) begin
            last_resp_cyc = cyc;
            resp_count++;
            vectors++;
            if (exp_resp.size() == 0) begin
                miscompares++;
                $display("FAIL resp_unexpected cyc=%0d got pc=%h required none", cyc, ldRespPc);
            end else begin
                r = exp_resp.pop_front();
                if (ldRespPc !== r.pc || ldRespData !== r.data) begin
                    miscompares++;
                    $display("FAIL load_resp cyc=%0d got pc=%h data=%h required pc=%h data=%h",
                             cyc, ldRespPc, ldRespData, r.pc, r.data);
                end
            end
        end
        @(posedge clk);
        #1;
        if (memReq && ack_en) begin
            if (wait_cnt >= ack_delay) begin
                memAck = 1'b1;
            end else begin
                memAck = 1'b0;
                wait_cnt++;
            end
        end else begin
            memAck = 1'b0;
            wait_cnt = 0;
        end
        memRdata = rd_fixed_en ? rd_fixed : mem_model(memAddr);
    endtask

    task automatic drain(output bit ok);
        int k = 0;
        ok = 1'b0;
        while (k < 200) begin
            tick();
            k++;
            if (exp_mem.size() == 0 && exp_resp.size() == 0 && !memReq) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic push_load(input logic [31:0] pc, input logic [31:0] a, input logic b);
        exp_mem.push_back('{1'b0, a, 32'h0, b});
        exp_resp.push_back('{pc, exp_load(a, b)});
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({ldReady, memReq, memWe, memByte, ldRespValid} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got=%b required=00000", {ldReady, memReq, memWe, memByte, ldRespValid});
        end
        vectors++;
        if ({stReady, stbEmpty} !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_flags got=%b required=11", {stReady, stbEmpty});
        end
        vectors++;
        if ({memAddr, memWdata, ldRespPc, ldRespData} !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_data got=%h required=0", {memAddr, memWdata, ldRespPc, ldRespData});
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_single_load();
        int g, extra;
        bit ok;
        ack_delay = 0;
        req_high_cyc = 0;
        last_resp_cyc = -100;
        extra = 0;
        ldValid = 1'b1; ldPc = 32'h1000; ldAddr = 32'h100; ldByte = 1'b0;
        push_load(32'h1000, 32'h100, 1'b0);
        tick();
        g = last_grant_cyc;
        vectors++;
        if (seen_ld_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_ready got=%b required=1", seen_ld_ready);
        end
        ldValid = 1'b0;
        repeat (4) begin
            tick();
            if (seen_ld_ready) extra++;
        end
        vectors++;
        if (extra != 0) begin
            miscompares++;
            $display("FAIL single_ready_once got=%0d extra required=0", extra);
        end
        vectors++;
        if (req_high_cyc != 1) begin
            miscompares++;
            $display("FAIL single_req_cycles got=%0d required=1", req_high_cyc);
        end
        vectors++;
        if (last_resp_cyc - g != 2) begin
            miscompares++;
            $display("FAIL single_latency got=%0d required=2", last_resp_cyc - g);
        end
        drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL single_drain got=timeout required=done");
        end
    endtask

    task automatic test_hazard();
        int k;
        bit ok;
        ack_delay = 1;
        vectors++;
        if (stReady !== 1'b1) begin
            miscompares++;
            $display("FAIL hazard_st_ready got=%b required=1", stReady);
        end
        stValid = 1'b1; stAddr = 32'h200; stData = 32'hDEADBEEF; stByte = 1'b0;
        exp_mem.push_back('{1'b1, 32'h200, 32'hDEADBEEF, 1'b0});
        tick();
        stValid = 1'b0;
        ldValid = 1'b1; ldPc = 32'h2000; ldAddr = 32'h202; ldByte = 1'b0;
        push_load(32'h2000, 32'h202, 1'b0);
        tick();
        vectors++;
        if (seen_ld_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL hazard_held got=%b required=0", seen_ld_ready);
        end
        k = 0;
        while (!seen_ld_ready && k < 20) begin
            tick();
            k++;
        end
        ldValid = 1'b0;
        vectors++;
        if (!seen_ld_ready || last_grant_cyc != last_st_ack_cyc + 1) begin
            miscompares++;
            $display("FAIL hazard_grant_after_ack got=%0d required=%0d", last_grant_cyc, last_st_ack_cyc + 1);
        end
        drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL hazard_drain got=timeout required=done");
        end
        ack_delay = 0;
    endtask

    task automatic test_fill();
        bit ok;
        ack_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            stValid = 1'b1;
            stAddr  = 32'h300 + 32'(4 * i);
            stData  = 32'h11111111 * 32'(i + 1);
            stByte  = (i == 2);
            vectors++;
            if (stReady !== 1'b1) begin
                miscompares++;
                $display("FAIL fill_ready_%0d got=%b required=1", i, stReady);
            end
            exp_mem.push_back('{1'b1, stAddr, stData, stByte});
            tick();
        end
        vectors++;
        if (stReady !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_full got=%b required=0", stReady);
        end
        stAddr = 32'h3F0; stData = 32'h00000BAD; stByte = 1'b0;
        tick();
        stValid = 1'b0;
        vectors++;
        if ({stReady, stbEmpty} !== 2'b00) begin
            miscompares++;
            $display("FAIL fill_still_full got=%b required=00", {stReady, stbEmpty});
        end
        ack_en = 1'b1;
        drain(ok);
        vectors++;
        if (!ok || {stReady, stbEmpty} !== 2'b11) begin
            miscompares++;
            $display("FAIL fill_drained got ok=%b flags=%b required ok=1 flags=11", ok, {stReady, stbEmpty});
        end
    endtask

    task automatic test_back_to_back();
        int g [4];
        int k;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            ldValid = 1'b1; ldPc = 32'h3000 + 32'(4 * i); ldAddr = 32'h700 + 32'(8 * i); ldByte = 1'b0;
            push_load(ldPc, ldAddr, 1'b0);
            k = 0;
            do begin
                tick();
                k++;
            end while (!seen_ld_ready && k < 20);
            g[i] = last_grant_cyc;
        end
        ldValid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            vectors++;
            if (g[i] - g[i-1] != 2) begin
                miscompares++;
                $display("FAIL b2b_interval_%0d got=%0d required=2", i, g[i] - g[i-1]);
            end
        end
        drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL b2b_drain got=timeout required=done");
        end
    endtask

    task automatic test_aging();
        int k;
        bit ok;
        mem_exp_t st;
        st = '{1'b1, 32'h900, 32'h5A5A0001, 1'b0};
        for (int i = 0; i < 9; i++) push_load(32'h5000 + 32'(4 * i), 32'h800 + 32'(4 * i), 1'b0);
`ifdef DMEM_ARB_AGE_EN
        exp_mem.push_back(st);
`endif
        for (int i = 9; i < 12; i++) push_load(32'h5000 + 32'(4 * i), 32'h800 + 32'(4 * i), 1'b0);
`ifndef DMEM_ARB_AGE_EN
        exp_mem.push_back(st);
`endif
        for (int i = 0; i < 12; i++) begin
            ldValid = 1'b1; ldPc = 32'h5000 + 32'(4 * i); ldAddr = 32'h800 + 32'(4 * i); ldByte = 1'b0;
            if (i == 1) begin
                stValid = 1'b1; stAddr = st.addr; stData = st.data; stByte = st.is_byte;
            end
            k = 0;
            do begin
                tick();
                stValid = 1'b0;
                k++;
            end while (!seen_ld_ready && k < 40);
            vectors++;
            if (!seen_ld_ready) begin
                miscompares++;
                $display("FAIL aging_load_%0d got=timeout required=grant", i);
            end
        end
        ldValid = 1'b0;
        vectors++;
`ifdef DMEM_ARB_AGE_EN
        if (stbEmpty !== 1'b1) begin
            miscompares++;
            $display("FAIL aging_store_forced got=%b required=1", stbEmpty);
        end
`else
        if (stbEmpty !== 1'b0) begin
            miscompares++;
            $display("FAIL aging_store_waits got=%b required=0", stbEmpty);
        end
`endif
        drain(ok);
        vectors++;
        if (!ok || stbEmpty !== 1'b1) begin
            miscompares++;
            $display("FAIL aging_drain got ok=%b empty=%b required ok=1 empty=1", ok, stbEmpty);
        end
    endtask

    task automatic test_byte_load();
        int k;
        bit ok;
        rd_fixed_en = 1'b1;
        rd_fixed = 32'hAABBCCDD;
        exp_mem.push_back('{1'b0, 32'h601, 32'h0, 1'b1});
        exp_resp.push_back('{32'h4000, 32'h000000DD});
        exp_mem.push_back('{1'b0, 32'h604, 32'h0, 1'b0});
        exp_resp.push_back('{32'h4004, 32'hAABBCCDD});
        for (int i = 0; i < 2; i++) begin
            ldValid = 1'b1; ldPc = 32'h4000 + 32'(4 * i);
            ldAddr = (i == 0) ? 32'h601 : 32'h604; ldByte = (i == 0);
            k = 0;
            do begin
                tick();
                k++;
            end while (!seen_ld_ready && k < 20);
        end
        ldValid = 1'b0;
        drain(ok);
        vectors++;
        if (!ok || ldRespData !== 32'hAABBCCDD) begin
            miscompares++;
            $display("FAIL byte_word_last got ok=%b data=%h required ok=1 data=aabbccdd", ok, ldRespData);
        end
        rd_fixed_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int r0;
        ack_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            stValid = 1'b1; stAddr = 32'hA00 + 32'(4 * i); stData = 32'hC0DE0000 + 32'(i); stByte = 1'b0;
            tick();
        end
        stValid = 1'b0;
        tick();
        vectors++;
        if (memReq !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_req_before got=%b required=1", memReq);
        end
        r0 = resp_count;
        #2;
        rstn = 1'b0;
        #1;
        vectors++;
        if (memReq !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_req_drop got=%b required=0", memReq);
        end
        ack_en = 1'b1;
        tick();
        tick();
        rstn = 1'b1;
        vectors++;
        if ({stbEmpty, stReady} !== 2'b11) begin
            miscompares++;
            $display("FAIL rstmid_empty got=%b required=11", {stbEmpty, stReady});
        end
        req_high_cyc = 0;
        repeat (6) tick();
        vectors++;
        if (resp_count != r0 || req_high_cyc != 0) begin
            miscompares++;
            $display("FAIL rstmid_quiet got resp=%0d req=%0d required resp=0 req=0", resp_count - r0, req_high_cyc);
        end
    endtask

    initial begin
        rstn = 1'b0;
        ldValid = 1'b0; ldPc = '0; ldAddr = '0; ldByte = 1'b0;
        stValid = 1'b0; stAddr = '0; stData = '0; stByte = 1'b0;
        memAck = 1'b0; memRdata = '0;
        ack_en = 1'b1; ack_delay = 0; wait_cnt = 0;
        rd_fixed_en = 1'b0; rd_fixed = '0;
        seen_ld_ready = 1'b0; prev_req = 1'b0; held_port = '0;
        last_grant_cyc = 0; last_resp_cyc = 0; last_st_ack_cyc = 0;
        req_high_cyc = 0; resp_count = 0;
        test_reset();
        test_single_load();
        test_hazard();
        test_fill();
        test_back_to_back();
        test_aging();
        test_byte_load();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
